// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/empty flags, read-valid strobe and sticky error flags.
//
// Ports:
//   CLK, RSTn        clock, async active-low reset
//   write, read      access requests (guarded when full/empty)
//   clr_err          sync clear of overflow/underflow
//   iData / oData    write data / registered read data
//   oValid           oData refreshed by last cycle's read
//   full, empty      occupancy extremes
//   almost_full      count >= AF_LEVEL
//   almost_empty     count <= AE_LEVEL
//   count            occupancy 0..DEPTH
//   overflow         sticky: a write was rejected
//   underflow        sticky: a read was rejected
module sfifo_param #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              write,
  input  logic              read,
  input  logic              clr_err,
  input  logic [DWIDTH-1:0] iData,
  output logic [DWIDTH-1:0] oData,
  output logic              oValid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [AWIDTH:0] DEPTH_V =
    {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF_V = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_V = AE_LEVEL[AWIDTH:0];

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH:0]   wp_q, wp_d;
  logic [AWIDTH:0]   rp_q, rp_d;
  logic [DWIDTH-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [AWIDTH:0]   cnt;
  logic              rd_acc;
  logic              wr_acc;

  // Extra pointer MSB distinguishes full from empty.
  assign cnt = wp_q - rp_q;

  assign count        = cnt;
  assign full         = (cnt == DEPTH_V);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_V);
  assign almost_empty = (cnt <= AE_V);

  assign rd_acc = read & ~empty;
  // A full FIFO can still take a word if a slot frees this cycle.
  assign wr_acc = write & (~full | rd_acc);

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    if (wr_acc) wp_d = wp_q + 1'b1;
    if (rd_acc) begin
      rp_d     = rp_q + 1'b1;
      odata_d  = mem[rp_q[AWIDTH-1:0]];
      ovalid_d = 1'b1;
    end
    // A new error in the same cycle as clr_err must survive.
    ovf_d = (write & ~wr_acc) | (ovf_q & ~clr_err);
    udf_d = (read & ~rd_acc) | (udf_q & ~clr_err);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp_q     <= '0;
      rp_q     <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wp_q[AWIDTH-1:0]] <= iData;
  end

  assign oData     = odata_q;
  assign oValid    = ovalid_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: random and directed stimulus for sfifo_param
// checked against a queue-based reference model.
module tb_sfifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] iData = '0;
  logic [DW-1:0] oData;
  logic          oValid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sfifo_param #(
    .DWIDTH(DW), .AWIDTH(AW),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .write(write), .read(read),
    .clr_err(clr_err), .iData(iData),
    .oData(oData), .oValid(oValid),
    .full(full), .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("afull", 32'(almost_full), 32'(n >= AF));
    chk("aempty", 32'(almost_empty), 32'(n <= AE));
    chk("oValid", 32'(oValid), 32'(m_valid));
    chk("oData", 32'(oData), 32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic step(input logic w, input logic r,
                      input logic c,
                      input logic [DW-1:0] d);
    bit ra, wa;
    write = w; read = r; clr_err = c; iData = d;
    @(posedge CLK);
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < DEPTH) || ra);
    m_valid = ra;
    if (ra) m_data = q.pop_front();
    if (wa) q.push_back(d);
    if (w && !wa)  m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
    if (r && !ra)  m_udf = 1'b1;
    else if (c)    m_udf = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] last;
    int n;

    #12 RSTn = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_oData", 32'(oData), 32'd0);
    check_all();
    step(0, 0, 0, 8'h00);

    // fill 0x01..0x10, then drain in order
    for (int i = 1; i <= 16; i++)
      step(1, 0, 0, DW'(i));
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 8'h00);
      chk("drain_data", 32'(oData), 32'(i));
    end
    step(0, 0, 0, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);

    // overflow, then write+read on full
    for (int i = 1; i <= 16; i++)
      step(1, 0, 0, DW'(i));
    step(1, 0, 0, 8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1, 1, 0, 8'hBB);
    chk("full_rw", 32'(oData), 32'h01);
    chk("full_rw_cnt", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      last = oData;
    end
    chk("bb_last", 32'(last), 32'hBB);

    // underflow and empty write+read
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("udf_set", 32'(underflow), 32'd1);
    step(1, 1, 0, 8'h55);
    chk("empty_rw_cnt", 32'(count), 32'd1);
    step(0, 0, 1, 8'h00);
    chk("udf_clr", 32'(underflow), 32'd0);
    step(0, 1, 0, 8'h00);
    chk("rd55", 32'(oData), 32'h55);

    // set coinciding with clr: set wins
    step(0, 1, 1, 8'h00);
    chk("set_wins", 32'(underflow), 32'd1);
    step(0, 0, 1, 8'h00);

    // stream 40 words, count kept within 1..5
    n = 0;
    while (n < 40) begin
      bit w, r;
      w = (q.size() < 5) && ($urandom_range(0, 2) != 0);
      r = (q.size() > 1) && ($urandom_range(0, 1) != 0);
      if (q.size() == 0) w = 1'b1;
      if (w) n++;
      step(w, r, 0, DW'($urandom));
    end
    while (q.size() > 0) step(0, 1, 0, 8'h00);
    chk("stream_ovf", 32'(overflow), 32'd0);
    chk("stream_udf", 32'(underflow), 32'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 250) % 3;
      step(($urandom_range(0, 3) < (bias + 1)),
           ($urandom_range(0, 3) < (3 - bias)),
           ($urandom_range(0, 15) == 0),
           DW'($urandom));
    end

    // async reset mid-burst at count 7
    step(0, 0, 1, 8'h00);
    while (q.size() > 0) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++)
      step(1, 0, 0, DW'(8'h30 + i));
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h40);
    chk("pre_rst_cnt", 32'(count), 32'd7);
    write = 1'b0; read = 1'b0; clr_err = 1'b0;
    #2 RSTn = 1'b0;
    #1 model_reset();
    chk("arst_cnt", 32'(count), 32'd0);
    check_all();
    #1 RSTn = 1'b1;
    step(1, 0, 0, 8'h77);
    step(0, 1, 0, 8'h00);
    chk("post_rst", 32'(oData), 32'h77);
    step(0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
Parametrised synchronous FIFO, the next-generation replacement for the fixed 16x8 sfifo. Width and depth are configurable. Writes into a full FIFO and reads from an empty FIFO are guarded and ignored. Adds occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe and sticky overflow/underflow error flags. Single clock domain; used as the byte/word buffer between the UART/peripheral side and the core bus side.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries (AWIDTH >= 1)
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTn  input  1  asynchronous active-low reset
write  input  1  write request
read  input  1  read request
clr_err  input  1  synchronous clear of the sticky error flags
iData  input  DWIDTH  write data
oData  output  DWIDTH  registered read data
oValid  output  1  one-cycle strobe: oData updated by a read accepted in the previous cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  AWIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (RSTn low, asynchronous): wp = rp = 0, oData = 0, oValid = 0, overflow = underflow = 0. Outputs then read count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0. RAM contents are not reset. Reset mid-operation discards all stored data immediately.
- Pointers: wp and rp are AWIDTH+1 bits wide and wrap modulo 2**(AWIDTH+1). RAM is indexed by the low AWIDTH bits. count = wp - rp, computed modulo 2**(AWIDTH+1).
- full, empty, almost_full, almost_empty and count are combinational from the registered pointers. They reflect state after the last clock edge.
- rd_acc = read & !empty.
- wr_acc = write & (!full | rd_acc). A write to a full FIFO is accepted only if a read is accepted in the same cycle.
- On rd_acc: oData <= RAM[rp[AWIDTH-1:0]] and rp <= rp + 1. Read latency is 1 cycle. oValid = 1 in the cycle after rd_acc, 0 otherwise. oData holds its value when there is no rd_acc.
- On wr_acc: RAM[wp[AWIDTH-1:0]] <= iData and wp <= wp + 1.
- Simultaneous read and write:
  - Empty: only the write is accepted; count goes to 1. The read is rejected, sets underflow, and data does not bypass to oData.
  - Full: both are accepted; count stays at DEPTH. oData takes the oldest entry, and the new word lands in the slot just freed.
  - Otherwise: both are accepted and count is unchanged.
- Errors:
  - overflow <= 1 when write & !wr_acc.
  - underflow <= 1 when read & !rd_acc.
  - Otherwise the flags clear to 0 on clr_err. If a set and clr_err coincide, the set wins.
- Rejected accesses change no pointer, RAM entry, oData or oValid.
- Pointer wrap-around is seamless: after 2**(AWIDTH+1) writes, wp returns to 0 with no effect on flags.

Test Plan:
- Reset, then idle -> count=0, empty=1, almost_empty=1, full=0, oValid=0, oData=0, overflow=underflow=0.
- Write 0x01..0x10 on 16 consecutive cycles (defaults) -> almost_empty drops when count=3, almost_full rises at count=12, full=1 at count=16. Then read 16 words -> oData = 0x01..0x10 in order, each with oValid high one cycle after its read, empty=1 at the end.
- Fill to 16, then write 0xAA alone -> rejected, count stays 16, overflow=1. Next cycle write+read with 0xBB -> count=16, oData=0x01, and 0xBB is read out last.
- Read while empty -> underflow=1, oValid stays 0, oData unchanged. Write+read while empty with 0x55 -> count=1, underflow remains 1. Assert clr_err -> underflow=0.
- Stream 40 words with interleaved reads, keeping count between 1 and 5 so the pointers wrap -> data order is preserved and no error flag is set.
- Assert RSTn low for a few ns mid-burst at count=7, asynchronous to CLK -> all outputs return to reset values immediately. The next write followed by a read returns the new word.
